// File: rtl/arm_mem_pkg.sv
// Shared types and address helpers for the MEM-stage SRAM controller.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } sram_state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    // 32-bit word index relative to the SRAM window; wraps modulo 2^32.
    function automatic logic [31:0] sram_word(input logic [31:0] byte_addr,
                                              input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Counts clocks within one SRAM half-access; tc marks the last clock of the phase.
module sram_phase_counter #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign tc = enable && (count == CW'(CYCLES - 1));

endmodule

// File: rtl/mem_sram_controller.sv
// MEM-stage controller: one 32-bit load/store as two 16-bit SRAM accesses, low half first.
module mem_sram_controller
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
    parameter int          ACCESS_CYCLES = 2,
    parameter int          SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        ST_val,
    output logic [31:0]        readdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    sram_state_t        state;
    sram_state_t        next_state;
    logic [SRAM_AW-2:0] cap_word;
    logic [31:0]        cap_data;
    logic               cap_load;
    logic               request;
    logic               active;
    logic               phase_done;

    assign request = MEM_R_EN || MEM_W_EN;
    assign active  = (state == LOW) || (state == HIGH);

    sram_phase_counter #(
        .CYCLES (ACCESS_CYCLES)
    ) u_phase_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (phase_done),
        .enable (active),
        .tc     (phase_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request) next_state = LOW;
            LOW:     if (phase_done) next_state = HIGH;
            HIGH:    if (phase_done) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: ready = !request;
            LOW: begin
                sram_addr = {cap_word, 1'b0};
                if (!cap_load) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = cap_data[15:0];
                end
            end
            HIGH: begin
                sram_addr = {cap_word, 1'b1};
                if (!cap_load) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = cap_data[31:16];
                end
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // The pipeline holds its request until ready, but the captured copy keeps
    // the SRAM bus stable even if the EXE register is flushed mid-access.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_word <= '0;
            cap_data <= '0;
            cap_load <= 1'b1;
        end else if (state == IDLE && request) begin
            cap_word <= (SRAM_AW-1)'(sram_word(ALU_result, BASE_ADDR));
            cap_data <= ST_val;
            cap_load <= MEM_R_EN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readdata <= '0;
        end else if (cap_load && phase_done) begin
            if (state == LOW) begin
                readdata[15:0] <= sram_dq_in;
            end else if (state == HIGH) begin
                readdata[31:16] <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Directed bench for mem_sram_controller with a behavioural 16-bit SRAM on the pads.
module tb_mem_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic [31:0] readdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] mem [0:262143];

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [17:0] exp_lo;
        logic [17:0] exp_hi;
        int          exp_we;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    mem_sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .ALU_result  (ALU_result),
        .ST_val      (ST_val),
        .readdata    (readdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    assign sram_dq_in = mem[sram_addr];

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Entered just after a rising edge; leaves just after the edge that ends DONE.
    task automatic run_vec(input vec_t v);
        int          k;
        int          low;
        int          we;
        int          oe;
        logic        done;
        logic [17:0] a_lo;
        logic [17:0] a_hi;
        logic [15:0] d_lo;
        logic [15:0] d_hi;
        k = 0; low = 0; we = 0; oe = 0; done = 1'b0;
        a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0;
        MEM_R_EN   = v.rd;
        MEM_W_EN   = v.wr;
        ALU_result = v.addr;
        ST_val     = v.data;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) check({v.name, " ready in request clock"}, 32'(ready), 32'd0);
            if (!sram_we_n) we++;
            if (sram_dq_oe) oe++;
            if (k == 2) begin a_lo = sram_addr; d_lo = sram_dq_out; end
            if (k == 4) begin a_hi = sram_addr; d_hi = sram_dq_out; end
            if (ready) done = 1'b1;
            else low++;
        end
        if (!done) check({v.name, " ready timeout"}, 32'(ready), 32'd1);
        check({v.name, " ready-low clocks"}, 32'(low), 32'd5);
        check({v.name, " we_n-low clocks"}, 32'(we), 32'(v.exp_we));
        check({v.name, " dq_oe clocks"}, 32'(oe), 32'(v.exp_we));
        check({v.name, " low-half addr"}, 32'(a_lo), 32'(v.exp_lo));
        check({v.name, " high-half addr"}, 32'(a_hi), 32'(v.exp_hi));
        check({v.name, " readdata in DONE"}, readdata, v.exp_rd);
        if (v.wr && !v.rd) begin
            check({v.name, " dq_out low"}, 32'(d_lo), 32'(v.data[15:0]));
            check({v.name, " dq_out high"}, 32'(d_hi), 32'(v.data[31:16]));
            check({v.name, " sram low word"}, 32'(mem[v.exp_lo]), 32'(v.data[15:0]));
            check({v.name, " sram high word"}, 32'(mem[v.exp_hi]), 32'(v.data[31:16]));
        end
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    initial begin
        vec_t tail;

        // Address 0: word 0x3FFFFF00, {word, half} truncated to 18 bits.
        vecs[0] = '{"store@1024", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0000_0000, 18'h00000, 18'h00001, 4};
        vecs[1] = '{"load@1024",  1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF,  18'h00000, 18'h00001, 0};
        vecs[2] = '{"store@1028", 1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF,  18'h00002, 18'h00003, 4};
        vecs[3] = '{"load@1028",  1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678,  18'h00002, 18'h00003, 0};
        vecs[4] = '{"both@1032",  1'b1, 1'b1, 32'd1032, 32'hFFFF0000, 32'hC3C35A5A,  18'h00004, 18'h00005, 0};
        vecs[5] = '{"load@0",     1'b1, 1'b0, 32'd0,    32'h0,        32'h22221111,  18'h3FE00, 18'h3FE01, 0};

        mem[4]        = 16'h5A5A;
        mem[5]        = 16'hC3C3;
        mem[18'h3FE00] = 16'h1111;
        mem[18'h3FE01] = 16'h2222;

        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = '0;
        ST_val     = '0;
        repeat (2) @(negedge clk);
        check("reset ready", 32'(ready), 32'd1);
        check("reset we_n", 32'(sram_we_n), 32'd1);
        check("reset dq_oe", 32'(sram_dq_oe), 32'd0);
        check("reset addr", 32'(sram_addr), 32'd0);
        check("reset readdata", readdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Consecutive vectors are issued back-to-back: the next request appears
        // in the clock right after DONE.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset during the first HIGH clock of a store.
        MEM_W_EN   = 1'b1;
        ALU_result = 32'd1036;
        ST_val     = 32'hCAFEF00D;
        repeat (4) @(negedge clk);
        check("pre-reset we_n in HIGH", 32'(sram_we_n), 32'd0);
        check("pre-reset addr in HIGH", 32'(sram_addr), 32'd7);
        rst      = 1'b1;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        check("post-reset ready", 32'(ready), 32'd1);
        check("post-reset we_n", 32'(sram_we_n), 32'd1);
        check("post-reset dq_oe", 32'(sram_dq_oe), 32'd0);
        check("post-reset addr", 32'(sram_addr), 32'd0);
        check("post-reset dq_out", 32'(sram_dq_out), 32'd0);
        check("post-reset readdata", readdata, 32'd0);
        check("interrupted store low half", 32'(mem[6]), 32'h0000F00D);
        @(posedge clk);
        #1;
        rst = 1'b0;

        tail = '{"load@1024 after reset", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'h00000, 18'h00001, 0};
        run_vec(tail);
        @(negedge clk);
        check("idle ready after access", 32'(ready), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
